// File: rtl/stack_unit_if.sv
// Signal bundle between the CPU datapath, the stack engine and the 16x8 data memory.
// valid/ready: an op_* request is taken when it is high at a rising edge with busy low; done marks completion.
interface stack_unit_if;
    logic       op_push;
    logic       op_pop;
    logic       op_call;
    logic       op_ret;
    logic [7:0] push_data;
    logic [7:0] ret_pc;
    logic [7:0] call_target;
    logic       clear_flags;
    logic [7:0] cpu_address;
    logic [7:0] cpu_data_in;
    logic       cpu_write_enable;
    logic [7:0] mem_data_out;
    logic [7:0] mem_address;
    logic [7:0] mem_data_in;
    logic       mem_write_enable;
    logic [7:0] pop_data;
    logic       pc_load;
    logic [7:0] pc_target;
    logic [7:0] sp;
    logic       busy;
    logic       done;
    logic       overflow;
    logic       underflow;
    logic [1:0] dbg_state;

    modport slave (
        input  op_push, op_pop, op_call, op_ret, push_data, ret_pc, call_target,
        input  clear_flags, cpu_address, cpu_data_in, cpu_write_enable, mem_data_out,
        output mem_address, mem_data_in, mem_write_enable, pop_data, pc_load, pc_target,
        output sp, busy, done, overflow, underflow, dbg_state
    );

    modport master (
        output op_push, op_pop, op_call, op_ret, push_data, ret_pc, call_target,
        output clear_flags, cpu_address, cpu_data_in, cpu_write_enable, mem_data_out,
        input  mem_address, mem_data_in, mem_write_enable, pop_data, pc_load, pc_target,
        input  sp, busy, done, overflow, underflow, dbg_state
    );
endinterface

// File: rtl/stack_unit.sv
// Downward-growing hardware stack in front of the data memory: PUSH/POP/CALL/RET
// run as short FSM sequences; when idle the CPU load/store path passes straight through.
module stack_unit #(
    parameter logic [7:0] STACK_TOP  = 8'd15,
    parameter int         STACK_SIZE = 8
) (
    input  logic         clk,
    input  logic         reset,
    stack_unit_if.slave  bus
);
    localparam int CW = $clog2(STACK_SIZE + 1);
    localparam logic [CW-1:0] FULL = CW'(STACK_SIZE);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_FINISH} state_t;

    state_t        r_state;
    logic [7:0]    r_sp;
    logic [CW-1:0] r_count;
    logic [7:0]    r_wval;
    logic [7:0]    r_pop_data;
    logic          r_is_call;
    logic          r_is_ret;
    logic          r_ok;
    logic          r_ovf;
    logic          r_udf;

    state_t        w_next_state;
    logic          w_accept;
    logic          w_is_wr;
    logic          w_is_call;
    logic          w_is_ret;
    logic [7:0]    w_wval;
    logic          w_set_ovf;
    logic          w_set_udf;
    logic          w_ok;
    logic          w_we;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    // Priority CALL > RET > PUSH > POP; losing requests are simply dropped.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_is_wr      = 1'b0;
        w_is_call    = 1'b0;
        w_is_ret     = 1'b0;
        w_wval       = 8'd0;
        w_set_ovf    = 1'b0;
        w_set_udf    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.op_call) begin
                    w_accept  = 1'b1;
                    w_is_wr   = 1'b1;
                    w_is_call = 1'b1;
                    w_wval    = bus.ret_pc;
                end else if (bus.op_ret) begin
                    w_accept = 1'b1;
                    w_is_ret = 1'b1;
                end else if (bus.op_push) begin
                    w_accept = 1'b1;
                    w_is_wr  = 1'b1;
                    w_wval   = bus.push_data;
                end else if (bus.op_pop) begin
                    w_accept = 1'b1;
                end
                if (w_accept) begin
                    if (w_is_wr) begin
                        if (r_count == FULL) begin
                            w_set_ovf    = 1'b1;
                            w_next_state = S_FINISH;
                        end else begin
                            w_next_state = S_WRITE;
                        end
                    end else if (r_count == '0) begin
                        w_set_udf    = 1'b1;
                        w_next_state = S_FINISH;
                    end else begin
                        w_next_state = S_READ;
                    end
                end
            end
            S_WRITE:  w_next_state = S_FINISH;
            S_READ:   w_next_state = S_FINISH;
            S_FINISH: w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    assign w_ok = w_accept & ~w_set_ovf & ~w_set_udf;

    always_comb begin
        bus.mem_address = r_sp;
        bus.mem_data_in = r_wval;
        w_we            = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.mem_address = bus.cpu_address;
                bus.mem_data_in = bus.cpu_data_in;
                w_we            = bus.cpu_write_enable;
            end
            S_WRITE: w_we = 1'b1;
            S_READ:  bus.mem_address = r_sp + 8'd1;
            default: w_we = 1'b0;
        endcase
    end

    // Gating by reset keeps a WRITE state caught by reset from touching memory.
    assign bus.mem_write_enable = w_we & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sp       <= STACK_TOP;
            r_count    <= '0;
            r_wval     <= 8'd0;
            r_pop_data <= 8'd0;
            r_is_call  <= 1'b0;
            r_is_ret   <= 1'b0;
            r_ok       <= 1'b0;
            r_ovf      <= 1'b0;
            r_udf      <= 1'b0;
        end else begin
            r_ovf <= w_set_ovf | (r_ovf & ~bus.clear_flags);
            r_udf <= w_set_udf | (r_udf & ~bus.clear_flags);
            if (w_accept) begin
                r_is_call <= w_is_call;
                r_is_ret  <= w_is_ret;
                r_ok      <= w_ok;
                if (w_is_wr) r_wval <= w_wval;
            end
            case (r_state)
                S_WRITE: begin
                    r_sp    <= r_sp - 8'd1;
                    r_count <= r_count + 1'b1;
                end
                S_READ: begin
                    r_pop_data <= bus.mem_data_out;
                    r_sp       <= r_sp + 8'd1;
                    r_count    <= r_count - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = (r_state == S_FINISH);
    assign bus.pc_load   = (r_state == S_FINISH) & r_ok & (r_is_call | r_is_ret);
    assign bus.pc_target = !bus.pc_load ? 8'd0 : (r_is_call ? bus.call_target : r_pop_data);
    assign bus.pop_data  = r_pop_data;
    assign bus.sp        = r_sp;
    assign bus.overflow  = r_ovf;
    assign bus.underflow = r_udf;
    assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_stack_unit.sv
// Bench for stack_unit: directed scenarios then random op mixes against a queue-based stack model.
module tb_stack_unit;
    logic clk;
    logic reset;
    stack_unit_if bus ();

    stack_unit #(.STACK_TOP(8'd15), .STACK_SIZE(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory environment: combinational read, write on the rising edge.
    logic [7:0] tb_mem [16];
    always @(posedge clk) if (bus.mem_write_enable) tb_mem[bus.mem_address[3:0]] <= bus.mem_data_in;
    assign bus.mem_data_out = tb_mem[bus.mem_address[3:0]];

    // Reference model
    logic [7:0] exp_q[$];
    logic [7:0] exp_mem [16];
    logic       m_ovf;
    logic       m_udf;
    logic [7:0] m_pop;

    int n_tests;
    int n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_sp();
        return 8'(15 - exp_q.size());
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        m_pop = 8'd0;
    endtask

    task automatic check_mem();
        for (int i = 0; i < 16; i++) chk($sformatf("mem[%0d]", i), tb_mem[i], exp_mem[i]);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset = 1'b1;
        repeat (cycles) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
    endtask

    task automatic cpu_write(input logic [7:0] addr, input logic [7:0] data);
        @(negedge clk);
        bus.cpu_address      = addr;
        bus.cpu_data_in      = data;
        bus.cpu_write_enable = 1'b1;
        @(posedge clk);
        #1 bus.cpu_write_enable = 1'b0;
        exp_mem[addr[3:0]] = data;
    endtask

    task automatic clear_pulse();
        @(negedge clk);
        bus.clear_flags = 1'b1;
        @(posedge clk);
        #1 bus.clear_flags = 1'b0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    // req = {call, ret, push, pop}
    task automatic do_op(input logic [3:0] req, input logic [7:0] pd, input logic [7:0] rp,
                         input logic [7:0] ct, input logic clr);
        logic       is_wr;
        logic       is_pc;
        logic       ok;
        logic [7:0] wv;
        logic [7:0] tgt;
        logic [7:0] sp0;
        if (req == 4'd0) return;
        is_wr = req[3] | (~req[2] & req[1]);
        is_pc = req[3] | req[2];
        wv    = req[3] ? rp : pd;
        ok    = is_wr ? (exp_q.size() < 8) : (exp_q.size() > 0);
        sp0   = m_sp();
        @(negedge clk);
        {bus.op_call, bus.op_ret, bus.op_push, bus.op_pop} = req;
        bus.push_data   = pd;
        bus.ret_pc      = rp;
        bus.call_target = ct;
        bus.clear_flags = clr;
        @(posedge clk);
        #1;
        {bus.op_call, bus.op_ret, bus.op_push, bus.op_pop} = 4'd0;
        bus.clear_flags = 1'b0;
        if (clr) begin
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end
        chk("busy_after_accept", bus.busy, 1);
        tgt = ct;
        if (ok) begin
            chk("done_early", bus.done, 0);
            chk("op_we", bus.mem_write_enable, is_wr);
            chk("op_addr", bus.mem_address, is_wr ? sp0 : sp0 + 8'd1);
            if (is_wr) chk("op_wdata", bus.mem_data_in, wv);
            @(posedge clk);
            #1;
            if (is_wr) begin
                exp_q.push_back(wv);
                exp_mem[sp0[3:0]] = wv;
            end else begin
                m_pop = exp_q.pop_back();
                tgt   = m_pop;
            end
        end else begin
            if (is_wr) m_ovf = 1'b1;
            else       m_udf = 1'b1;
        end
        chk("done", bus.done, 1);
        chk("pc_load", bus.pc_load, ok & is_pc);
        if (ok & is_pc) chk("pc_target", bus.pc_target, tgt);
        @(posedge clk);
        #1;
        chk("done_end", bus.done, 0);
        chk("busy_end", bus.busy, 0);
        chk("sp", bus.sp, m_sp());
        chk("pop_data", bus.pop_data, m_pop);
        chk("overflow", bus.overflow, m_ovf);
        chk("underflow", bus.underflow, m_udf);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 16; i++) begin
            tb_mem[i]  = 8'd0;
            exp_mem[i] = 8'd0;
        end
        reset = 1'b0;
        {bus.op_call, bus.op_ret, bus.op_push, bus.op_pop} = 4'd0;
        bus.push_data        = 8'd0;
        bus.ret_pc           = 8'd0;
        bus.call_target      = 8'd0;
        bus.clear_flags      = 1'b0;
        bus.cpu_address      = 8'd0;
        bus.cpu_data_in      = 8'd0;
        bus.cpu_write_enable = 1'b0;

        do_reset(2);
        chk("rst_sp", bus.sp, 15);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_pc_load", bus.pc_load, 0);
        chk("rst_pc_target", bus.pc_target, 0);
        chk("rst_pop_data", bus.pop_data, 0);
        chk("rst_ovf", bus.overflow, 0);
        chk("rst_udf", bus.underflow, 0);
        chk("rst_state", bus.dbg_state, 0);

        cpu_write(8'd3, 8'h5A);
        check_mem();

        do_op(4'b0010, 8'hA1, 8'h00, 8'h00, 1'b0);
        chk("push_mem15", tb_mem[15], 8'hA1);
        do_op(4'b0001, 8'h00, 8'h00, 8'h00, 1'b0);
        chk("pop_val", bus.pop_data, 8'hA1);
        check_mem();

        do_op(4'b1000, 8'h00, 8'h21, 8'h40, 1'b0);
        do_op(4'b0100, 8'h00, 8'h00, 8'h00, 1'b0);
        chk("ret_sp", bus.sp, 15);

        for (int i = 0; i < 8; i++) do_op(4'b0010, 8'(8'h10 + i), 8'h00, 8'h00, 1'b0);
        chk("full_sp", bus.sp, 7);
        do_op(4'b0010, 8'hEE, 8'h00, 8'h00, 1'b0);
        check_mem();
        for (int i = 0; i < 8; i++) begin
            do_op(4'b0001, 8'h00, 8'h00, 8'h00, 1'b0);
            chk("lifo_order", bus.pop_data, 8'(8'h17 - i));
        end

        clear_pulse();
        do_op(4'b0001, 8'h00, 8'h00, 8'h00, 1'b0);
        clear_pulse();
        chk("udf_cleared", bus.underflow, 0);
        do_op(4'b0100, 8'h00, 8'h00, 8'h00, 1'b0);
        do_op(4'b0001, 8'h00, 8'h00, 8'h00, 1'b1);

        do_op(4'b1010, 8'h77, 8'h33, 8'h50, 1'b0);
        chk("arb_mem15", tb_mem[15], 8'h33);
        do_op(4'b0100, 8'h00, 8'h00, 8'h00, 1'b0);

        // CPU write request during the stack's WRITE cycle is dropped.
        @(negedge clk);
        bus.push_data   = 8'h66;
        bus.op_push     = 1'b1;
        bus.cpu_address = 8'd2;
        bus.cpu_data_in = 8'hEE;
        @(posedge clk);
        #1 bus.op_push = 1'b0;
        bus.cpu_write_enable = 1'b1;
        @(posedge clk);
        #1 bus.cpu_write_enable = 1'b0;
        @(posedge clk);
        #1;
        exp_mem[m_sp()] = 8'h66;
        exp_q.push_back(8'h66);
        chk("cpuwe_sp", bus.sp, m_sp());
        check_mem();
        do_op(4'b0001, 8'h00, 8'h00, 8'h00, 1'b0);

        // Reset landing in the WRITE cycle.
        @(negedge clk);
        bus.push_data = 8'h99;
        bus.op_push   = 1'b1;
        @(posedge clk);
        #1 bus.op_push = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        chk("rstw_sp", bus.sp, 15);
        chk("rstw_state", bus.dbg_state, 0);
        chk("rstw_busy", bus.busy, 0);
        chk("rstw_done", bus.done, 0);
        check_mem();

        for (int n = 0; n < 300; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) clear_pulse();
            else if (r == 1) cpu_write(8'($urandom_range(0, 6)), 8'($urandom));
            else do_op(4'($urandom_range(1, 15)), 8'($urandom), 8'($urandom), 8'($urandom),
                       $urandom_range(0, 7) == 0);
            if (n % 50 == 49) check_mem();
        end
        check_mem();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
